// File: rtl/shift_det_pkg.sv
// shift_det_pkg: shared FSM encoding, default parameters and counter saturation helper.
// Contents: state_t (IDLE/SEARCH/TRACK/LOCKED), DEF_* parameter defaults, cnt_max().
package shift_det_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SEARCH = 2'b01,
      TRACK  = 2'b10,
      LOCKED = 2'b11
   } state_t;
   localparam int DEF_WIDTH       = 8;
   localparam int DEF_PERIOD      = 8;
   localparam int DEF_LOCK_THRESH = 3;
   localparam int DEF_MISS_LIMIT  = 2;
   localparam int DEF_CNT_W       = 8;
   function automatic logic [63:0] cnt_max(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction
endpackage

// File: rtl/shift_pattern_detector_if.sv
// shift_pattern_detector_if: bundle between the shift register side and the pattern detector.
// Signals: q_in/q_valid (register state), pat_in/pat_load (pattern programming),
//          pat_mask (only with SHIFT_DET_MASK_EN), match/match_count/locked/state/phase (results).
// Modports: master drives stimulus and observes results; slave is the detector.
interface shift_pattern_detector_if #(
   parameter int WIDTH  = shift_det_pkg::DEF_WIDTH,
   parameter int PERIOD = shift_det_pkg::DEF_PERIOD,
   parameter int CNT_W  = shift_det_pkg::DEF_CNT_W
);
   localparam int PH_W = $clog2(PERIOD);
   logic [WIDTH-1:0] q_in;
   logic             q_valid;
   logic [WIDTH-1:0] pat_in;
   logic             pat_load;
`ifdef SHIFT_DET_MASK_EN
   logic [WIDTH-1:0] pat_mask;
`endif
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             locked;
   logic [1:0]       state;
   logic [PH_W-1:0]  phase;
   modport master (
      output q_in, q_valid, pat_in, pat_load,
`ifdef SHIFT_DET_MASK_EN
      output pat_mask,
`endif
      input  match, match_count, locked, state, phase
   );
   modport slave (
      input  q_in, q_valid, pat_in, pat_load,
`ifdef SHIFT_DET_MASK_EN
      input  pat_mask,
`endif
      output match, match_count, locked, state, phase
   );
endinterface

// File: rtl/shift_det_phase_ctr.sv
// shift_det_phase_ctr: modulo-PERIOD count of valid shifts since the last anchor or checkpoint.
// Ports: clk, rst (sync, active-high), clr (force phase to 0), en (a valid shift this cycle),
//        phase (current count), checkpoint (en while phase == PERIOD-1).
module shift_det_phase_ctr import shift_det_pkg::*; #(
   parameter int PERIOD = DEF_PERIOD,
   localparam int PH_W  = $clog2(PERIOD)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   output logic [PH_W-1:0] phase,
   output logic            checkpoint
);
   assign checkpoint = en && phase == PH_W'(PERIOD - 1);
   always_ff @(posedge clk)
      if (rst || clr) phase <= '0;
      else if (en) phase <= checkpoint ? '0 : phase + 1'b1;
endmodule

// File: rtl/shift_pattern_detector.sv
// shift_pattern_detector: matches each shifted register state against a programmed pattern,
// counts hits and locks onto a pattern that recurs every PERIOD valid shifts.
// Ports: clk, rst (sync, active-high), bus (shift_pattern_detector_if.slave).
// Build option: SHIFT_DET_MASK_EN adds bus.pat_mask so masked-off bits are don't-care.
module shift_pattern_detector import shift_det_pkg::*; #(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int PERIOD      = DEF_PERIOD,
   parameter int LOCK_THRESH = DEF_LOCK_THRESH,
   parameter int MISS_LIMIT  = DEF_MISS_LIMIT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input logic                     clk,
   input logic                     rst,
   shift_pattern_detector_if.slave bus
);
   localparam int HIT_W = $clog2(LOCK_THRESH + 1);
   localparam int MISS_W = $clog2(MISS_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
   state_t            state;
   logic [WIDTH-1:0]  pat;
   logic [WIDTH-1:0]  mask;
   logic [HIT_W-1:0]  hits;
   logic [MISS_W-1:0] misses;
   logic              active;
   logic              hit;
   logic              checkpoint;
`ifdef SHIFT_DET_MASK_EN
   assign mask = bus.pat_mask;
`else
   assign mask = '1;
`endif
   assign active = state != IDLE;
   assign hit = bus.q_valid && ((bus.q_in & mask) == (pat & mask));
   assign bus.state = state;
   // A SEARCH hit anchors the period, so the phase restarts there.
   shift_det_phase_ctr #(.PERIOD(PERIOD)) u_phase (
      .clk        (clk),
      .rst        (rst),
      .clr        (bus.pat_load || (state == SEARCH && hit)),
      .en         (bus.q_valid && active),
      .phase      (bus.phase),
      .checkpoint (checkpoint)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         pat             <= '0;
         hits            <= '0;
         misses          <= '0;
         bus.match       <= 1'b0;
         bus.match_count <= '0;
         bus.locked      <= 1'b0;
      end else if (bus.pat_load) begin
         state           <= SEARCH;
         pat             <= bus.pat_in;
         hits            <= '0;
         misses          <= '0;
         bus.match       <= 1'b0;
         bus.match_count <= '0;
         bus.locked      <= 1'b0;
      end else begin
         bus.match <= active && hit;
         if (active && hit && bus.match_count != CNT_MAX) bus.match_count <= bus.match_count + 1'b1;
         if (state == SEARCH && hit) begin
            state <= TRACK;
            hits  <= HIT_W'(1);
         end else if (state == TRACK && checkpoint) begin
            if (!hit) begin
               state <= SEARCH;
               hits  <= '0;
            end else begin
               hits <= hits + 1'b1;
               if (int'(hits) + 1 == LOCK_THRESH) begin
                  state      <= LOCKED;
                  bus.locked <= 1'b1;
                  misses     <= '0;
               end
            end
         end else if (state == LOCKED && checkpoint) begin
            if (hit) misses <= '0;
            else begin
               misses <= misses + 1'b1;
               if (int'(misses) + 1 == MISS_LIMIT) begin
                  state      <= SEARCH;
                  bus.locked <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_shift_pattern_detector.sv
// tb_shift_pattern_detector: table-driven and directed checks of shift_pattern_detector.
module tb_shift_pattern_detector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   shift_pattern_detector_if bus ();
   shift_pattern_detector dut (.clk(clk), .rst(rst), .bus(bus));
   int tests = 0;
   int fails = 0;
   typedef struct {
      logic       r;
      logic       pl;
      logic [7:0] pi;
      logic       qv;
      logic [7:0] qi;
      logic       m;
      logic [7:0] c;
      logic [1:0] st;
      logic       lk;
      logic [2:0] ph;
   } vec_t;
   vec_t tbl[$];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic r, input logic pl, input logic [7:0] pi, input logic qv, input logic [7:0] qi);
      @(negedge clk);
      rst = r;
      bus.pat_load = pl;
      bus.pat_in = pi;
      bus.q_valid = qv;
      bus.q_in = qi;
      @(posedge clk);
      #1;
   endtask
   task automatic expect_all(input string tag, input logic m, input logic [7:0] c, input logic [1:0] st,
                             input logic lk, input logic [2:0] ph);
      check({tag, " match"}, 32'(bus.match), 32'(m));
      check({tag, " count"}, 32'(bus.match_count), 32'(c));
      check({tag, " state"}, 32'(bus.state), 32'(st));
      check({tag, " locked"}, 32'(bus.locked), 32'(lk));
      check({tag, " phase"}, 32'(bus.phase), 32'(ph));
   endtask
   initial begin
      bus.pat_load = 1'b0;
      bus.pat_in = '0;
      bus.q_valid = 1'b0;
      bus.q_in = '0;
`ifdef SHIFT_DET_MASK_EN
      bus.pat_mask = 8'hFF;
`endif
      drive(1, 0, 8'h00, 0, 8'h00);
      drive(1, 0, 8'h00, 1, 8'h00);
      expect_all("reset", 0, 0, 2'b00, 0, 0);
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 8'h00, 1, 8'(i * 13));
         check($sformatf("idle%0d state", i), 32'(bus.state), 0);
         check($sformatf("idle%0d match", i), 32'(bus.match), 0);
         check($sformatf("idle%0d count", i), 32'(bus.match_count), 0);
      end
      drive(0, 1, 8'h01, 0, 8'h00);
      expect_all("load01", 0, 0, 2'b01, 0, 0);
      for (int k = 0; k <= 32; k++) begin
         vec_t v;
         v.r  = 0;
         v.pl = 0;
         v.pi = 0;
         v.qv = 1;
         v.qi = (k == 24 || k == 32) ? 8'h00 : 8'(8'h01 << (k % 8));
         v.m  = (k % 8 == 0) && k < 24;
         v.c  = k < 24 ? 8'(k / 8 + 1) : 8'd3;
         v.st = k == 32 ? 2'b01 : (k >= 16 ? 2'b11 : 2'b10);
         v.lk = k >= 16 && k < 32;
         v.ph = 3'(k % 8);
         tbl.push_back(v);
      end
      tbl.push_back('{r: 0, pl: 0, pi: 0, qv: 0, qi: 8'h01, m: 0, c: 3, st: 2'b01, lk: 0, ph: 0});
      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].pl, tbl[i].pi, tbl[i].qv, tbl[i].qi);
         expect_all($sformatf("vec%0d", i), tbl[i].m, tbl[i].c, tbl[i].st, tbl[i].lk, tbl[i].ph);
      end
      drive(0, 1, 8'hB6, 1, 8'hB6);
      expect_all("loadB6", 0, 0, 2'b01, 0, 0);
      drive(0, 0, 8'h00, 1, 8'hB6);
      expect_all("firstB6", 1, 1, 2'b10, 0, 0);
`ifdef SHIFT_DET_MASK_EN
      bus.pat_mask = 8'h0F;
`endif
      drive(0, 1, 8'h0F, 0, 8'h00);
      drive(0, 0, 8'h00, 1, 8'hAF);
`ifdef SHIFT_DET_MASK_EN
      expect_all("mask", 1, 1, 2'b10, 0, 0);
      bus.pat_mask = 8'hFF;
`else
      expect_all("nomask", 0, 0, 2'b01, 0, 1);
`endif
      drive(0, 1, 8'hFF, 0, 8'h00);
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, 8'h00, 1, 8'hFF);
         if (i == 253) check("sat254 count", 32'(bus.match_count), 254);
         if (i == 254) check("sat255 count", 32'(bus.match_count), 255);
      end
      expect_all("sat", 1, 8'd255, 2'b11, 1, 3);
      drive(1, 1, 8'h55, 1, 8'h55);
      expect_all("midrst", 0, 0, 2'b00, 0, 0);
      drive(0, 0, 8'h00, 1, 8'h00);
      expect_all("idle_after_rst", 0, 0, 2'b00, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
